// File: rtl/feature_stream_out_if.sv
// Valid/ready stream carrying one feature word plus its (channel, row, column) coordinates.
interface feature_stream_out_if #(
    parameter int WIDTH = 8,
    parameter int C     = 16,
    parameter int H     = 4,
    parameter int W     = 4
) ();
    localparam int CW = $clog2(C);
    localparam int RW = $clog2(H);
    localparam int KW = $clog2(W);

    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CW-1:0]    m_ch;
    logic [RW-1:0]    m_row;
    logic [KW-1:0]    m_col;
    logic             m_last;

    modport master (
        output m_valid, m_data, m_ch, m_row, m_col, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_ch, m_row, m_col, m_last,
        output m_ready
    );
endinterface

// File: rtl/feature_stream_out.sv
// Snapshots a C x H x W feature map on capture and streams it word by word,
// channel-major, over a valid/ready interface.
module feature_stream_out #(
    parameter int WIDTH = 8,
    parameter int C     = 16,
    parameter int H     = 4,
    parameter int W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] z [0:C-1][0:H-1][0:W-1],
    input  logic             capture,
    output logic             busy,
    output logic             done,
    feature_stream_out_if.master bus
);
    localparam int CW = $clog2(C);
    localparam int RW = $clog2(H);
    localparam int KW = $clog2(W);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state;
    logic [CW-1:0]    ch;
    logic [RW-1:0]    row;
    logic [KW-1:0]    col;
    logic [WIDTH-1:0] buf_q [0:C-1][0:H-1][0:W-1];

    logic ch_max, row_max, col_max;
    assign ch_max  = (ch  == CW'(C - 1));
    assign row_max = (row == RW'(H - 1));
    assign col_max = (col == KW'(W - 1));

    // NOTE: the snapshot buffer has no reset; it is only read in STREAM, after a capture has filled it.
    always_ff @(posedge clk) begin
        if (state == IDLE && capture) begin
            buf_q <= z;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch    <= '0;
            row   <= '0;
            col   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        ch    <= '0;
                        row   <= '0;
                        col   <= '0;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.m_ready) begin
                        if (!col_max) begin
                            col <= col + 1'b1;
                        end else begin
                            col <= '0;
                            if (!row_max) begin
                                row <= row + 1'b1;
                            end else begin
                                row <= '0;
                                if (!ch_max) begin
                                    ch <= ch + 1'b1;
                                end else begin
                                    ch    <= '0;
                                    state <= IDLE;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; m_data is forced to 0 outside a frame.
    assign busy        = (state == STREAM);
    assign bus.m_valid = (state == STREAM);
    assign bus.m_ch    = ch;
    assign bus.m_row   = row;
    assign bus.m_col   = col;
    assign bus.m_last  = (state == STREAM) && ch_max && row_max && col_max;
    assign bus.m_data  = (state == STREAM) ? buf_q[ch][row][col] : '0;
endmodule

// File: doc/feature_stream_out.md
# feature_stream_out

Output-side serializer for the LeNet feature pipeline. On a capture request it snapshots the parallel final feature map (C×H×W words, 16×4×4 by default) that the convolution/pool stack produces, then streams the words one per handshake over a valid/ready interface, in channel-major order. It lets the fully parallel feature array be read out by a narrow downstream consumer such as a dense layer, a FIFO or a host link.

## Interface
- WIDTH, 8, bits per feature word
- C, 16, number of channels
- H, 4, rows per channel
- W, 4, columns per channel
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous, active-high reset
- z  in  WIDTH × [C][H][W] (unpacked array `[WIDTH-1:0] z[0:C-1][0:H-1][0:W-1]`)  parallel feature map, sampled only on an accepted capture
- capture  in  1  request to snapshot `z` and start streaming
- busy  out  1  high from the accepted capture until the final beat is accepted
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream ready
- m_data  out  WIDTH  current feature word
- m_ch  out  $clog2(C)  channel index of m_data
- m_row  out  $clog2(H)  row index of m_data
- m_col  out  $clog2(W)  column index of m_data
- m_last  out  1  high with the final word (index C*H*W-1)
- done  out  1  one-cycle pulse the cycle after the final handshake

## Operation
- States: IDLE, STREAM.
- IDLE: busy=0, m_valid=0. When capture=1, copy all of z into the internal buffer, clear the index counters (ch, row, col) to 0, and go to STREAM.
- STREAM: busy=1, m_valid=1, m_data=buf[ch][row][col], indices drive m_ch, m_row and m_col.
- A handshake is m_valid && m_ready. On a handshake, advance col. When col wraps from W-1 to 0, advance row. When row wraps from H-1 to 0, advance ch. Order: ch outer, row middle, col inner.
- m_last = (ch==C-1 && row==H-1 && col==W-1) while in STREAM.
- Handshake on the last word: go to IDLE and assert done for the next cycle only.
- capture is ignored while in STREAM, including the cycle of the final handshake. The buffer is never overwritten mid-frame, and changes on z during STREAM have no effect.
- m_ready while in IDLE is ignored.
- Index counters and the buffer are plain registers. No arithmetic on the data; words pass through bit-exact.

## Timing
- Reset: state=IDLE, busy=0, m_valid=0, m_last=0, done=0, m_ch/m_row/m_col=0, m_data=0. Buffer contents are don't-care.
- rst takes priority over capture and handshakes. A reset mid-STREAM drops the frame at the next edge; no done pulse is issued.
- Capture accepted at edge t: m_valid=1 with word 0 from edge t onward (first data visible the cycle after capture is sampled).
- Throughput is 1 word/cycle with m_ready held high. A frame takes C*H*W cycles from the first m_valid to the final handshake, plus 1 cycle for done.
- Back-pressure: while m_valid && !m_ready, m_data, m_ch, m_row, m_col and m_last hold stable. m_valid never drops before the handshake.
- Earliest next capture: the cycle done is high. So the minimum frame period is C*H*W+1 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from m_ready or capture to any output.

## Test plan
- Reset then idle: hold rst for 2 cycles, pulse m_ready and capture low -> all outputs 0, and busy stays 0.
- Full stream with ready high: set z[c][r][k] = c*16+r*4+k and pulse capture -> 256 beats with m_data = 0..255 in order and indices matching. m_last is high only on beat 255. done pulses 1 cycle after it, busy falls together with done.
- Back-pressure: toggle m_ready pseudo-randomly (about 50%) -> identical sequence of 0..255. The outputs stay stable on every stalled cycle, and the total handshake count is 256.
- Snapshot isolation: capture with pattern A, then drive z with pattern B and pulse capture repeatedly during STREAM -> the stream outputs pattern A only, no second frame starts, and a single done pulse is seen.
- Reset mid-frame: assert rst after beat 100 -> the next cycle shows m_valid=0, busy=0 and no done pulse. A new capture then restarts from index (0,0,0).
- Back-to-back frames: assert capture in the done cycle with a new pattern -> the second frame starts with m_valid on the following cycle, giving a gap of exactly 1 cycle between the final beat and the new word 0.
